seq_stream_8b_minmax: RTL and testbench
=======================================

// Module: seq_stream_8b_minmax
//
// PURPOSE
//   Streaming consumer for 8-bit unsigned compare results. It accepts a packet of
//   8-bit unsigned values over a val/rdy stream, with in_last marking the final
//   element. For each packet it reports the minimum, maximum and element count.
//   It sits directly downstream of the input stream and wraps two 8-bit unsigned
//   comparators whose lt/gt outputs drive the running-extreme updates.
//
// PARAMETERS
//   CNT_WIDTH   8   width of out_count; the count saturates at 2**CNT_WIDTH-1
//
// PORTS
//   clk        in   1          clock, rising-edge
//   reset      in   1          asynchronous, active-high reset
//   in_val     in   1          input element valid
//   in_rdy     out  1          block can accept an input element
//   in_data    in   8          unsigned input element
//   in_last    in   1          element is the last of its packet; qualified by in_val
//   out_val    out  1          result valid
//   out_rdy    in   1          consumer accepts the result
//   out_min    out  8          packet minimum (unsigned)
//   out_max    out  8          packet maximum (unsigned)
//   out_count  out  CNT_WIDTH  elements in the packet, saturating
//
// BEHAVIOUR
//   - Input transfer: in_val & in_rdy on a rising clk. Output transfer: out_val & out_rdy.
//   - FSM states: EMPTY (no packet in progress), ACCUM (packet open), OUTPUT (result held).
//   - in_rdy = (state != OUTPUT). out_val = (state == OUTPUT). Both are Moore outputs.
//   - EMPTY + input transfer:
//     - min <= max <= in_data; count <= 1.
//     - Next state is OUTPUT if in_last, otherwise ACCUM.
//   - ACCUM + input transfer:
//     - min <= in_data if in_data < min; max <= in_data if in_data > max.
//     - Equal values leave both unchanged.
//     - count <= count+1, saturating at all-ones.
//     - Next state is OUTPUT if in_last, otherwise stays ACCUM.
//   - OUTPUT:
//     - out_min, out_max and out_count are held stable while out_val & !out_rdy.
//     - On out_rdy the block goes to EMPTY. No input is accepted in the same cycle.
//   - Latency: out_val asserts the cycle after the in_last transfer.
//     - Minimum packet period is 2 cycles: a 1-element packet, then one output cycle.
//   - No transfer: all state holds. in_data and in_last are ignored when in_val=0.
//   - Comparisons are unsigned 8-bit: 8'h80 > 8'h7F, and 8'hFF is the largest value.
//   - Reset, asynchronous, including mid-packet:
//     - State goes to EMPTY and any partial packet is discarded.
//     - min=8'hFF, max=8'h00, count=0, out_val=0, in_rdy=1.
//     - out_min, out_max and out_count show these register values.
//
// STRUCTURE
//   - Shared package seq_minmax_pkg:
//     - typedef enum logic [1:0] {EMPTY, ACCUM, OUTPUT} minmax_state_t;
//     - localparam MINMAX_DATA_W = 8.
//   - Sub-module arith_8b_ucmp(in0, in1 -> lt, eq, gt), purely combinational, two instances:
//     - u_cmp_min: in0 = in_data, in1 = min; its lt drives the min update.
//     - u_cmp_max: in0 = in_data, in1 = max; its gt drives the max update.
//   - Registers:
//     - state, min, max, count.
//     - out_* are driven directly from min/max/count; there is no extra output register.
//
// TESTING
//   1. Single element: send 42 with last=1, out_rdy=1.
//      -> Next cycle out_val=1, min=42, max=42, count=1. Then EMPTY and in_rdy=1.
//   2. Packet 13, 200, 3, 128(last):
//      -> min=3, max=200, count=4. out_val=1 exactly one cycle after the 128 transfer.
//   3. Unsigned boundary, packet 127, 128, 0, 255(last):
//      -> min=0, max=255, count=4.
//      Packet 128, 127(last) -> min=127, max=128.
//   4. Backpressure: after packet 5, 9(last), hold out_rdy=0 for 3 cycles while in_val=1.
//      -> in_rdy=0, outputs stay min=5, max=9, count=2.
//      Raise out_rdy -> the next packet starts fresh.
//   5. Saturation: CNT_WIDTH=8, 300 elements of 16 with last on the 300th.
//      -> count=255, min=max=16.
//      In-packet in_val bubbles do not change the result.
//   6. Reset mid-packet: send 50, 60, then assert reset asynchronously between edges.
//      -> Immediately state=EMPTY, out_val=0, min=8'hFF, max=0, count=0.
//      Next packet 7(last) -> min=max=7, count=1.
//   - Every scenario compares against a behavioural model, plus 20 random packets
//     of random length 1..8 with random in_val/out_rdy stalls.

Source files
------------

// File: rtl/seq_minmax_pkg.sv
// rtl/seq_minmax_pkg.sv - shared types and constants for the packet min/max block
//
// Purpose: FSM state encoding and data width used by seq_stream_8b_minmax.
// Ports:   none (package).

package seq_minmax_pkg;

  localparam int MINMAX_DATA_W = 8;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } minmax_state_t;

endpackage

// File: rtl/arith_8b_ucmp.sv
// rtl/arith_8b_ucmp.sv - combinational 8-bit unsigned comparator
//
// Purpose: compares in0 against in1 as unsigned values.
// Ports:   in0, in1 (8-bit operands) -> lt (in0 < in1), eq (in0 == in1), gt (in0 > in1).

module arith_8b_ucmp
  import seq_minmax_pkg::*;
(
  input  logic [MINMAX_DATA_W-1:0] in0,
  input  logic [MINMAX_DATA_W-1:0] in1,
  output logic                     lt,
  output logic                     eq,
  output logic                     gt
);

  always_comb begin
    lt = (in0 < in1);
    eq = (in0 == in1);
    gt = (in0 > in1);
  end

endmodule

// File: rtl/seq_stream_8b_minmax.sv
// rtl/seq_stream_8b_minmax.sv - per-packet min/max/count of an 8-bit unsigned stream
//
// Purpose: accepts a val/rdy packet stream (in_last closes a packet) and presents
//          the packet minimum, maximum and saturating element count on a val/rdy
//          result port.
// Ports:   clk, reset (async, active-high)
//          in_val/in_rdy/in_data[7:0]/in_last  - element stream
//          out_val/out_rdy                     - result handshake
//          out_min[7:0], out_max[7:0], out_count[CNT_WIDTH-1:0] - result

module seq_stream_8b_minmax
  import seq_minmax_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [MINMAX_DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [MINMAX_DATA_W-1:0] out_min,
  output logic [MINMAX_DATA_W-1:0] out_max,
  output logic [CNT_WIDTH-1:0]     out_count
);

  minmax_state_t              state_q, state_d;
  logic [MINMAX_DATA_W-1:0]   min_q, min_d;
  logic [MINMAX_DATA_W-1:0]   max_q, max_d;
  logic [CNT_WIDTH-1:0]       count_q, count_d;

  logic in_xfer;
  logic cmp_min_lt, cmp_min_eq, cmp_min_gt;
  logic cmp_max_lt, cmp_max_eq, cmp_max_gt;
  logic min_upd, max_upd;

  arith_8b_ucmp u_cmp_min (
    .in0 (in_data),
    .in1 (min_q),
    .lt  (cmp_min_lt),
    .eq  (cmp_min_eq),
    .gt  (cmp_min_gt)
  );

  arith_8b_ucmp u_cmp_max (
    .in0 (in_data),
    .in1 (max_q),
    .lt  (cmp_max_lt),
    .eq  (cmp_max_eq),
    .gt  (cmp_max_gt)
  );

  // A tie never replaces the held extreme; the opposite-direction flags are
  // irrelevant to each running extreme.
  assign min_upd = cmp_min_lt & ~cmp_min_eq & ~cmp_min_gt;
  assign max_upd = cmp_max_gt & ~cmp_max_eq & ~cmp_max_lt;

  assign in_xfer = in_val & in_rdy;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY, ACCUM: begin
        if (in_xfer) begin
          state_d = in_last ? OUTPUT : ACCUM;
        end
      end
      OUTPUT: begin
        if (out_rdy) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Moore outputs
  always_comb begin
    in_rdy  = (state_q != OUTPUT);
    out_val = (state_q == OUTPUT);
  end

  // Datapath next-state: the first element of a packet seeds both extremes.
  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    if (in_xfer) begin
      if (state_q == EMPTY) begin
        min_d   = in_data;
        max_d   = in_data;
        count_d = CNT_WIDTH'(1);
      end else begin
        if (min_upd) begin
          min_d = in_data;
        end
        if (max_upd) begin
          max_d = in_data;
        end
        if (count_q != {CNT_WIDTH{1'b1}}) begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q   <= {MINMAX_DATA_W{1'b1}};
      max_q   <= '0;
      count_q <= '0;
    end else begin
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
    end
  end

  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_seq_stream_8b_minmax.sv
// tb/tb_seq_stream_8b_minmax.sv - directed and random checks for seq_stream_8b_minmax

module tb_seq_stream_8b_minmax;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_min;
  logic [7:0] out_max;
  logic [7:0] out_count;

  int vectors = 0;
  int miscompares = 0;

  // {out_val, in_rdy, out_min, out_max, out_count}
  logic [25:0] snap;
  assign snap = {out_val, in_rdy, out_min, out_max, out_count};

  seq_stream_8b_minmax #(.CNT_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    in_val  = 1'b1;
    in_data = d;
    in_last = l;
    n = 0;
    while (!in_rdy && n < 50) begin
      step();
      n++;
    end
    if (!in_rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_rdy=%b required 1", in_rdy);
    end
    step();
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic collect();
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] exp;
    exp = {1'b0, 1'b1, 8'hFF, 8'h00, 8'd0};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL reset_state: got %h required %h", snap, exp);
    end
  endtask

  task automatic test_single();
    logic [25:0] exp;
    send(8'd42, 1'b1);
    exp = {1'b1, 1'b0, 8'd42, 8'd42, 8'd1};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL single_result: got %h required %h", snap, exp);
    end
    collect();
    exp = {1'b0, 1'b1, 8'd42, 8'd42, 8'd1};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL single_empty: got %h required %h", snap, exp);
    end
  endtask

  task automatic test_packet4();
    logic [25:0] exp;
    send(8'd13, 1'b0);
    send(8'd200, 1'b0);
    send(8'd3, 1'b0);
    exp = {1'b0, 1'b1, 8'd3, 8'd200, 8'd3};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL packet4_mid: got %h required %h", snap, exp);
    end
    send(8'd128, 1'b1);
    exp = {1'b1, 1'b0, 8'd3, 8'd200, 8'd4};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL packet4_result: got %h required %h", snap, exp);
    end
    collect();
  endtask

  task automatic test_unsigned();
    logic [25:0] exp;
    send(8'd127, 1'b0);
    send(8'd128, 1'b0);
    send(8'd0, 1'b0);
    send(8'd255, 1'b1);
    exp = {1'b1, 1'b0, 8'd0, 8'd255, 8'd4};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL unsigned_full: got %h required %h", snap, exp);
    end
    collect();
    send(8'h80, 1'b0);
    send(8'h7F, 1'b1);
    exp = {1'b1, 1'b0, 8'h7F, 8'h80, 8'd2};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL unsigned_80_7f: got %h required %h", snap, exp);
    end
    collect();
  endtask

  task automatic test_backpressure();
    logic [25:0] exp;
    send(8'd5, 1'b0);
    send(8'd9, 1'b1);
    in_val  = 1'b1;
    in_data = 8'd77;
    in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 1'b0, 8'd5, 8'd9, 8'd2};
      vectors++;
      if (snap !== exp) begin
        miscompares++;
        $display("FAIL backpressure_hold%0d: got %h required %h", i, snap, exp);
      end
      step();
    end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    exp = {1'b0, 1'b1, 8'd5, 8'd9, 8'd2};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL backpressure_release: got %h required %h", snap, exp);
    end
    step();
    in_val  = 1'b0;
    in_last = 1'b0;
    exp = {1'b1, 1'b0, 8'd77, 8'd77, 8'd1};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL backpressure_fresh: got %h required %h", snap, exp);
    end
    collect();
  endtask

  task automatic test_saturation();
    logic [25:0] exp;
    for (int i = 1; i <= 300; i++) begin
      if (i % 37 == 0) begin
        in_val  = 1'b0;
        in_data = 8'h00;
        in_last = 1'b1;
        step();
      end
      send(8'd16, i == 300);
    end
    exp = {1'b1, 1'b0, 8'd16, 8'd16, 8'd255};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL saturation: got %h required %h", snap, exp);
    end
    collect();
  endtask

  task automatic test_reset_mid();
    logic [25:0] exp;
    send(8'd50, 1'b0);
    send(8'd60, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    exp = {1'b0, 1'b1, 8'hFF, 8'h00, 8'd0};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL reset_mid: got %h required %h", snap, exp);
    end
    #2;
    reset = 1'b0;
    step();
    send(8'd7, 1'b1);
    exp = {1'b1, 1'b0, 8'd7, 8'd7, 8'd1};
    vectors++;
    if (snap !== exp) begin
      miscompares++;
      $display("FAIL reset_next_packet: got %h required %h", snap, exp);
    end
    collect();
  endtask

  task automatic test_random();
    logic [25:0] exp;
    logic [7:0]  d, mn, mx;
    int len, stall;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 8);
      mn = 8'hFF;
      mx = 8'h00;
      for (int e = 0; e < len; e++) begin
        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) begin
          in_val  = 1'b0;
          in_data = 8'($urandom);
          in_last = 1'($urandom);
          step();
        end
        d = 8'($urandom);
        if (d < mn) mn = d;
        if (d > mx) mx = d;
        send(d, e == len - 1);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        exp = {1'b1, 1'b0, mn, mx, 8'(len)};
        vectors++;
        if (snap !== exp) begin
          miscompares++;
          $display("FAIL random_pkt%0d: got %h required %h", p, snap, exp);
        end
        if (s < stall) step();
      end
      collect();
    end
  endtask

  initial begin
    reset   = 1'b1;
    in_val  = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    out_rdy = 1'b0;
    #12;
    test_reset();
    reset = 1'b0;
    step();
    test_single();
    test_packet4();
    test_unsigned();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
